// File: rtl/ddr_dqs_rcvr_cal_ctrl_pkg.sv
// Shared DDR definitions used by the DQS receiver offset-calibration sequencer.
package ddr_global_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT0,
        SAMP0,
        STEP,
        WAIT,
        SAMP,
        NEXT,
        DONE
    } dqs_rcvr_cal_state_t;

    localparam int   DQS_CAL_SYNC_STAGES = 2;
    localparam logic DQS_CAL_LEG_T       = 1'b0;
    localparam logic DQS_CAL_LEG_C       = 1'b1;

endpackage

// File: rtl/ddr_dqs_rcvr_cal_ctrl_if.sv
// Control/observation bundle between the calibration sequencer and the DQS receiver.
interface ddr_dqs_rcvr_cal_ctrl_if #(
    parameter int CAL_W    = 4,
    parameter int SETTLE_W = 8
);
    logic                i_cal_start;
    logic [SETTLE_W-1:0] i_settle_cnt;
    logic                i_dqs_t;
    logic                i_dqs_c;
    logic                o_rcvr_ena;
    logic                o_rxcal_ena;
    logic [CAL_W-1:0]    o_cal_p_t;
    logic [CAL_W-1:0]    o_cal_n_t;
    logic [CAL_W-1:0]    o_cal_p_c;
    logic [CAL_W-1:0]    o_cal_n_c;
    logic                o_busy;
    logic                o_done;
    logic                o_err_t;
    logic                o_err_c;

    // Sequencer side.
    modport slave (
        input  i_cal_start, i_settle_cnt, i_dqs_t, i_dqs_c,
        output o_rcvr_ena, o_rxcal_ena, o_cal_p_t, o_cal_n_t, o_cal_p_c, o_cal_n_c,
        output o_busy, o_done, o_err_t, o_err_c
    );

    // Requester / receiver side.
    modport master (
        output i_cal_start, i_settle_cnt, i_dqs_t, i_dqs_c,
        input  o_rcvr_ena, o_rxcal_ena, o_cal_p_t, o_cal_n_t, o_cal_p_c, o_cal_n_c,
        input  o_busy, o_done, o_err_t, o_err_c
    );
endinterface

// File: rtl/ddr_dqs_rcvr_cal_ctrl_demet.sv
// Multi-flop demetastabiliser for a single asynchronous level signal.
module ddr_demet_r #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[STAGES-1];
endmodule

// File: rtl/ddr_dqs_rcvr_cal_ctrl.sv
// DQS differential receiver offset-calibration sequencer.
// With the receiver in rxcal mode (inputs shorted), each leg (T then C) sweeps
// its P or N code upward from 0 until the receiver output flips, then holds it.
//
// state | meaning
// IDLE  | waiting for a start pulse, codes hold last result
// WAIT0 | settle after leg entry before the first (direction) sample
// SAMP0 | sample active leg: 0 -> sweep P toward 1, 1 -> sweep N toward 0
// STEP  | bump the selected code, or flag saturation at max
// WAIT  | settle after a code change
// SAMP  | compare sample with target; flip ends the leg
// NEXT  | advance T -> C, or finish after C
// DONE  | drop enables, raise done
module ddr_dqs_rcvr_cal_ctrl
    import ddr_global_pkg::*;
#(
    parameter int CAL_W    = 4,
    parameter int SETTLE_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    ddr_dqs_rcvr_cal_ctrl_if.slave  cal_if
);
    // Wait counter holds W-1 = max(settle,1)+1, which needs one extra bit.
    localparam int               CNT_W    = SETTLE_W + 1;
    localparam logic [CAL_W-1:0] CODE_MAX = '1;

    dqs_rcvr_cal_state_t state_q, state_d;

    logic [CNT_W-1:0]    wait_cnt_q;
    logic [CNT_W-1:0]    wait_load;
    logic [SETTLE_W-1:0] settle_eff;
    logic                leg_q;
    logic                dir_q;
    logic [CAL_W-1:0]    p_t_q, n_t_q, p_c_q, n_c_q;
    logic [CAL_W-1:0]    sel_code;
    logic                rcvr_ena_q, rxcal_ena_q, busy_q, done_q, err_t_q, err_c_q;
    logic                dqs_t_sync, dqs_c_sync;
    logic                leg_sample;
    logic                target;
    logic                in_wait;

    logic                start_acc, load_wait, samp_dir, inc_code, set_err, leg_to_c, finish;

    ddr_demet_r #(.STAGES(DQS_CAL_SYNC_STAGES)) u_demet_t (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (cal_if.i_dqs_t),
        .o_q   (dqs_t_sync)
    );

    ddr_demet_r #(.STAGES(DQS_CAL_SYNC_STAGES)) u_demet_c (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (cal_if.i_dqs_c),
        .o_q   (dqs_c_sync)
    );

    // A zero settle count still gets one cycle; the +1 covers the synchroniser
    // so the counter spans W = settle_eff + 2 cycles when loaded with W-1.
    assign settle_eff = (cal_if.i_settle_cnt == '0) ? SETTLE_W'(1) : cal_if.i_settle_cnt;
    assign wait_load  = {1'b0, settle_eff} + CNT_W'(1);

    assign leg_sample = (leg_q == DQS_CAL_LEG_C) ? dqs_c_sync : dqs_t_sync;
    assign target     = ~dir_q;
    assign in_wait    = (state_q == WAIT0) || (state_q == WAIT);

    // Pick the code currently being swept for the active leg and direction.
    always_comb begin
        sel_code = '0;
        unique case ({leg_q, dir_q})
            2'b00:   sel_code = p_t_q;
            2'b01:   sel_code = n_t_q;
            2'b10:   sel_code = p_c_q;
            default: sel_code = n_c_q;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        load_wait = 1'b0;
        samp_dir  = 1'b0;
        inc_code  = 1'b0;
        set_err   = 1'b0;
        leg_to_c  = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cal_if.i_cal_start) begin
                    start_acc = 1'b1;
                    load_wait = 1'b1;
                    state_d   = WAIT0;
                end
            end
            WAIT0: begin
                if (wait_cnt_q == '0) begin
                    state_d = SAMP0;
                end
            end
            SAMP0: begin
                samp_dir = 1'b1;
                state_d  = STEP;
            end
            STEP: begin
                if (sel_code == CODE_MAX) begin
                    set_err = 1'b1;
                    state_d = NEXT;
                end else begin
                    inc_code  = 1'b1;
                    load_wait = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = SAMP;
                end
            end
            SAMP: begin
                state_d = (leg_sample == target) ? NEXT : STEP;
            end
            NEXT: begin
                if (leg_q == DQS_CAL_LEG_T) begin
                    leg_to_c  = 1'b1;
                    load_wait = 1'b1;
                    state_d   = WAIT0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Settle timer: loaded on every wait entry, counts down to terminal zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt_q <= '0;
        end else if (load_wait) begin
            wait_cnt_q <= wait_load;
        end else if (in_wait && (wait_cnt_q != '0)) begin
            wait_cnt_q <= wait_cnt_q - CNT_W'(1);
        end
    end

    // Calibration codes, leg/direction select and status flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            leg_q       <= DQS_CAL_LEG_T;
            dir_q       <= 1'b0;
            p_t_q       <= '0;
            n_t_q       <= '0;
            p_c_q       <= '0;
            n_c_q       <= '0;
            rcvr_ena_q  <= 1'b0;
            rxcal_ena_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_t_q     <= 1'b0;
            err_c_q     <= 1'b0;
        end else begin
            if (start_acc) begin
                leg_q       <= DQS_CAL_LEG_T;
                dir_q       <= 1'b0;
                p_t_q       <= '0;
                n_t_q       <= '0;
                p_c_q       <= '0;
                n_c_q       <= '0;
                rcvr_ena_q  <= 1'b1;
                rxcal_ena_q <= 1'b1;
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
                err_t_q     <= 1'b0;
                err_c_q     <= 1'b0;
            end
            if (samp_dir) begin
                dir_q <= leg_sample;
            end
            if (inc_code) begin
                unique case ({leg_q, dir_q})
                    2'b00:   p_t_q <= p_t_q + CAL_W'(1);
                    2'b01:   n_t_q <= n_t_q + CAL_W'(1);
                    2'b10:   p_c_q <= p_c_q + CAL_W'(1);
                    default: n_c_q <= n_c_q + CAL_W'(1);
                endcase
            end
            if (set_err) begin
                if (leg_q == DQS_CAL_LEG_C) begin
                    err_c_q <= 1'b1;
                end else begin
                    err_t_q <= 1'b1;
                end
            end
            if (leg_to_c) begin
                leg_q <= DQS_CAL_LEG_C;
            end
            if (finish) begin
                rcvr_ena_q  <= 1'b0;
                rxcal_ena_q <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
            end
        end
    end

    assign cal_if.o_rcvr_ena  = rcvr_ena_q;
    assign cal_if.o_rxcal_ena = rxcal_ena_q;
    assign cal_if.o_cal_p_t   = p_t_q;
    assign cal_if.o_cal_n_t   = n_t_q;
    assign cal_if.o_cal_p_c   = p_c_q;
    assign cal_if.o_cal_n_c   = n_c_q;
    assign cal_if.o_busy      = busy_q;
    assign cal_if.o_done      = done_q;
    assign cal_if.o_err_t     = err_t_q;
    assign cal_if.o_err_c     = err_c_q;
endmodule

// File: tb/tb_ddr_dqs_rcvr_cal_ctrl.sv
// Bench for the DQS receiver calibration sequencer: a threshold model of the
// shorted-input receiver, a driver issuing calibrations, and a monitor that
// scores each completion against a queue of predicted results.
module tb_ddr_dqs_rcvr_cal_ctrl;
    localparam int CAL_W    = 4;
    localparam int SETTLE_W = 8;
    localparam int CODE_MAX = (1 << CAL_W) - 1;
    localparam int RUN_BUDGET = 3000;

    typedef struct {
        int p_t, n_t, p_c, n_c;
        int err_t, err_c;
        int cycles;
        int w;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ddr_dqs_rcvr_cal_ctrl_if #(.CAL_W(CAL_W), .SETTLE_W(SETTLE_W)) cal_if ();

    ddr_dqs_rcvr_cal_ctrl #(.CAL_W(CAL_W), .SETTLE_W(SETTLE_W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .cal_if (cal_if)
    );

    always #5 clk = ~clk;

    int n_checks    = 0;
    int n_fail      = 0;
    int n_expected  = 0;
    int n_completed = 0;
    int cyc         = 0;
    exp_t exp_q[$];

    // Receiver model: each leg idles at 'base'; it flips once the code that
    // pulls against the offset reaches 'th'. th beyond CODE_MAX never flips.
    bit rx_base_t = 1'b0;
    bit rx_base_c = 1'b0;
    int rx_th_t   = 1;
    int rx_th_c   = 1;

    assign cal_if.i_dqs_t = rx_base_t ^ (int'(rx_base_t ? cal_if.o_cal_n_t : cal_if.o_cal_p_t) >= rx_th_t);
    assign cal_if.i_dqs_c = rx_base_c ^ (int'(rx_base_c ? cal_if.o_cal_n_c : cal_if.o_cal_p_c) >= rx_th_c);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void leg_model(input bit base, input int th, input int w,
                                      output int p, output int n, output int err, output int dur);
        int code;
        err  = (th > CODE_MAX) ? 1 : 0;
        code = (err != 0) ? CODE_MAX : th;
        p    = base ? 0 : code;
        n    = base ? code : 0;
        // W+1 for the first settle+direction sample, W+2 per increment,
        // plus the final STEP that discovers saturation.
        dur  = (w + 1) + code * (w + 2) + err;
    endfunction

    function automatic exp_t cal_model(input int settle, input bit bt, input int tht,
                                       input bit bc, input int thc);
        exp_t e;
        int dur_t, dur_c;
        e.w = ((settle == 0) ? 1 : settle) + 2;
        leg_model(bt, tht, e.w, e.p_t, e.n_t, e.err_t, dur_t);
        leg_model(bc, thc, e.w, e.p_c, e.n_c, e.err_c, dur_c);
        // Two NEXT cycles and the DONE cycle are also spent busy.
        e.cycles = dur_t + dur_c + 3;
        return e;
    endfunction

    function automatic logic [21:0] all_outputs();
        return {cal_if.o_rcvr_ena, cal_if.o_rxcal_ena, cal_if.o_cal_p_t, cal_if.o_cal_n_t,
                cal_if.o_cal_p_c, cal_if.o_cal_n_c, cal_if.o_busy, cal_if.o_done,
                cal_if.o_err_t, cal_if.o_err_c};
    endfunction

    // Monitor: scores each busy->idle completion and the spacing of code steps.
    int          mon_busy_cnt  = 0;
    bit          mon_prev_busy = 1'b0;
    logic [15:0] mon_prev_codes = '0;
    bit          mon_have_prev = 1'b0;
    bit          mon_last_leg  = 1'b0;
    int          mon_last_cyc  = 0;

    initial begin : monitor
        exp_t e;
        logic [15:0] codes;
        bit t_chg, c_chg;
        forever begin
            @(negedge clk);
            codes = {cal_if.o_cal_p_t, cal_if.o_cal_n_t, cal_if.o_cal_p_c, cal_if.o_cal_n_c};
            if (rst) begin
                mon_busy_cnt   = 0;
                mon_prev_busy  = 1'b0;
                mon_have_prev  = 1'b0;
                mon_prev_codes = codes;
            end else begin
                if (cal_if.o_busy) begin
                    mon_busy_cnt++;
                    t_chg = (codes[15:8] != mon_prev_codes[15:8]) && (codes[15:8] != 8'd0);
                    c_chg = (codes[7:0] != mon_prev_codes[7:0]) && (codes[7:0] != 8'd0);
                    if (t_chg || c_chg) begin
                        if (mon_have_prev && (mon_last_leg == c_chg) && (exp_q.size() > 0))
                            chk("step_spacing", cyc - mon_last_cyc, exp_q[0].w + 2);
                        mon_have_prev = 1'b1;
                        mon_last_leg  = c_chg;
                        mon_last_cyc  = cyc;
                    end
                end
                if (mon_prev_busy && !cal_if.o_busy) begin
                    mon_have_prev = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        n_completed++;
                        chk("p_t", cal_if.o_cal_p_t, e.p_t);
                        chk("n_t", cal_if.o_cal_n_t, e.n_t);
                        chk("p_c", cal_if.o_cal_p_c, e.p_c);
                        chk("n_c", cal_if.o_cal_n_c, e.n_c);
                        chk("err_t", cal_if.o_err_t, e.err_t);
                        chk("err_c", cal_if.o_err_c, e.err_c);
                        chk("done", cal_if.o_done, 1);
                        chk("enables_off", {cal_if.o_rcvr_ena, cal_if.o_rxcal_ena}, 0);
                        chk("busy_cycles", mon_busy_cnt, e.cycles);
                    end
                    mon_busy_cnt = 0;
                end
                mon_prev_busy  = cal_if.o_busy;
                mon_prev_codes = codes;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        cal_if.i_cal_start = 1'b1;
        @(negedge clk);
        cal_if.i_cal_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        n_expected = n_completed;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic setup(input int settle, input bit bt, input int tht, input bit bc, input int thc);
        rx_base_t = bt;
        rx_th_t   = tht;
        rx_base_c = bc;
        rx_th_c   = thc;
        cal_if.i_settle_cnt = SETTLE_W'(settle);
        exp_q.push_back(cal_model(settle, bt, tht, bc, thc));
        n_expected++;
    endtask

    task automatic run_cal(input string tag, input int settle, input bit bt, input int tht,
                           input bit bc, input int thc, input bit poke);
        int waited;
        setup(settle, bt, tht, bc, thc);
        pulse_start();
        chk({tag, "_start_accept"}, {cal_if.o_busy, cal_if.o_done, cal_if.o_rcvr_ena, cal_if.o_rxcal_ena}, 4'b1011);
        if (poke) begin
            repeat (20) @(negedge clk);
            cal_if.i_cal_start = 1'b1;
            @(negedge clk);
            cal_if.i_cal_start = 1'b0;
            chk({tag, "_busy_after_poke"}, cal_if.o_busy, 1);
        end
        waited = 0;
        while (cal_if.o_busy && (waited < RUN_BUDGET)) begin
            @(negedge clk);
            waited++;
        end
        if (cal_if.o_busy) begin
            chk({tag, "_timeout"}, waited, 0);
            do_reset();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : driver
        int waited;
        cal_if.i_cal_start  = 1'b0;
        cal_if.i_settle_cnt = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outputs(), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_cal("nominal", 4, 1'b0, 5, 1'b1, 3, 1'b0);
        chk("done_sticky", cal_if.o_done, 1);
        run_cal("immediate", 4, 1'b0, 1, 1'b1, 1, 1'b0);
        run_cal("saturate_t", 4, 1'b0, CODE_MAX + 1, 1'b0, 7, 1'b0);
        run_cal("settle0", 0, 1'b1, 4, 1'b0, 6, 1'b0);
        run_cal("start_busy", 4, 1'b0, 5, 1'b1, 3, 1'b1);

        // Abort in the middle of the T sweep, then recalibrate from scratch.
        setup(4, 1'b0, 8, 1'b1, 3);
        pulse_start();
        waited = 0;
        while ((cal_if.o_cal_p_t != 4'd3) && (waited < RUN_BUDGET)) begin
            @(negedge clk);
            waited++;
        end
        chk("reset_pt3_reached", cal_if.o_cal_p_t, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        n_expected = n_completed;
        #1 chk("reset_abort_outputs", all_outputs(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_cal("after_reset", 4, 1'b0, 8, 1'b1, 3, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_cal("random", int'($urandom_range(10, 0)),
                    1'($urandom_range(1, 0)), int'($urandom_range(CODE_MAX + 1, 1)),
                    1'($urandom_range(1, 0)), int'($urandom_range(CODE_MAX + 1, 1)), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("completion_count", n_completed, n_expected);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
